// File: rtl/hazard_scoreboard.sv
// Writeback tracker and hazard unit: decodes the ID instruction, mirrors its
// destination record through EX..WB, and derives forwarding selects, a
// load-use / late-result stall, and a saturating stall-cycle counter.
module hazard_scoreboard #(
   parameter int DEPTH     = 3,
   parameter int LATE_LAT  = 1,
   parameter int JUMP_LATE = 0,
   parameter int SELW      = $clog2(DEPTH + 1)
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic [31:0]     id_inst,
   input  logic            id_valid,
   input  logic            flush,
   output logic            stall,
   output logic [SELW-1:0] fwd_rs1,
   output logic [SELW-1:0] fwd_rs2,
   output logic [4:0]      ws,
   output logic [31:0]     stall_cnt
);

   localparam logic [4:0] OP_LOAD  = 5'b00000;
   localparam logic [4:0] OP_ICAL  = 5'b00100;
   localparam logic [4:0] OP_AUIPC = 5'b00101;
   localparam logic [4:0] OP_S     = 5'b01000;
   localparam logic [4:0] OP_R     = 5'b01100;
   localparam logic [4:0] OP_LUI   = 5'b01101;
   localparam logic [4:0] OP_B     = 5'b11000;
   localparam logic [4:0] OP_JALR  = 5'b11001;
   localparam logic [4:0] OP_JAL   = 5'b11011;

   logic [4:0]      opc, rd, rs1, rs2;
   logic            dec_we, dec_late, use_rs1, use_rs2;
   logic [SELW-1:0] sel1, sel2;
   logic            late1, late2;
   logic            unused_bits;

   // Entry 0 = EX, DEPTH-1 = WB.
   logic            ent_v    [DEPTH];
   logic [4:0]      ent_rd   [DEPTH];
   logic            ent_we   [DEPTH];
   logic            ent_late [DEPTH];

   assign opc         = id_inst[6:2];
   assign rd          = id_inst[11:7];
   assign rs1         = id_inst[19:15];
   assign rs2         = id_inst[24:20];
   assign ws          = rd;
   assign unused_bits = ^{id_inst[31:25], id_inst[14:12], id_inst[1:0]};

   // Decode write-enable, late-result and source-usage flags of the ID instruction.
   always_comb begin
      dec_we   = 1'b0;
      dec_late = 1'b0;
      use_rs1  = 1'b0;
      use_rs2  = 1'b0;
      case (opc)
         OP_R:          begin dec_we = 1'b1; use_rs1 = 1'b1; use_rs2 = 1'b1; end
         OP_S, OP_B:    begin use_rs1 = 1'b1; use_rs2 = 1'b1; end
         OP_ICAL:       begin dec_we = 1'b1; use_rs1 = 1'b1; end
         OP_LOAD:       begin dec_we = 1'b1; dec_late = 1'b1; use_rs1 = 1'b1; end
         OP_JALR:       begin dec_we = 1'b1; dec_late = (JUMP_LATE != 0); use_rs1 = 1'b1; end
         OP_JAL:        begin dec_we = 1'b1; dec_late = (JUMP_LATE != 0); end
         OP_LUI, OP_AUIPC: dec_we = 1'b1;
         default:       ;
      endcase
      if (rd == 5'd0) dec_we = 1'b0;
   end

   // Youngest-match search: scan oldest to youngest so the lowest entry wins.
   always_comb begin
      sel1  = '0;
      sel2  = '0;
      late1 = 1'b0;
      late2 = 1'b0;
      for (int unsigned i = DEPTH; i > 0; i--) begin
         if (ent_v[i-1] && ent_we[i-1] && (ent_rd[i-1] == rs1) && (rs1 != 5'd0)) begin
            sel1  = SELW'(i);
            late1 = ent_late[i-1] && (int'(i) <= LATE_LAT);
         end
         if (ent_v[i-1] && ent_we[i-1] && (ent_rd[i-1] == rs2) && (rs2 != 5'd0)) begin
            sel2  = SELW'(i);
            late2 = ent_late[i-1] && (int'(i) <= LATE_LAT);
         end
      end
   end

   assign fwd_rs1 = id_valid ? sel1 : '0;
   assign fwd_rs2 = id_valid ? sel2 : '0;
   assign stall   = id_valid & ~flush & ((use_rs1 & late1) | (use_rs2 & late2));

   // Shift the scoreboard; entry 0 takes the ID record or a bubble.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int unsigned i = 0; i < DEPTH; i++) begin
            ent_v[i]    <= 1'b0;
            ent_rd[i]   <= '0;
            ent_we[i]   <= 1'b0;
            ent_late[i] <= 1'b0;
         end
      end else begin
         for (int unsigned i = 1; i < DEPTH; i++) begin
            ent_v[i]    <= ent_v[i-1];
            ent_rd[i]   <= ent_rd[i-1];
            ent_we[i]   <= ent_we[i-1];
            ent_late[i] <= ent_late[i-1];
         end
         ent_v[0]    <= id_valid & ~stall & ~flush;
         ent_rd[0]   <= rd;
         ent_we[0]   <= dec_we;
         ent_late[0] <= dec_late;
      end
   end

   // Saturating count of stall cycles.
   always_ff @(posedge clk) begin
      if (!rst_n)
         stall_cnt <= '0;
      else if (stall && (stall_cnt != '1))
         stall_cnt <= stall_cnt + 32'd1;
   end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Bench for hazard_scoreboard: two instances (JUMP_LATE=0 and 1) share one
// stimulus stream; a queue-based reference model predicts each cycle's outputs
// and a negedge monitor pops and compares them.
module tb_hazard_scoreboard;
   localparam int DEPTH    = 3;
   localparam int LATE_LAT = 1;
   localparam int SELW     = $clog2(DEPTH + 1);
   localparam longint CMAX = 64'hFFFF_FFFF;

   logic            clk = 1'b0;
   logic            rst_n = 1'b0;
   logic [31:0]     id_inst = '0;
   logic            id_valid = 1'b0;
   logic            flush = 1'b0;
   logic            stall_a, stall_b;
   logic [SELW-1:0] f1_a, f2_a, f1_b, f2_b;
   logic [4:0]      ws_a, ws_b;
   logic [31:0]     cnt_a, cnt_b;

   always #5 clk = ~clk;

   hazard_scoreboard #(.DEPTH(DEPTH), .LATE_LAT(LATE_LAT), .JUMP_LATE(0)) dut_a (
      .clk(clk), .rst_n(rst_n), .id_inst(id_inst), .id_valid(id_valid), .flush(flush),
      .stall(stall_a), .fwd_rs1(f1_a), .fwd_rs2(f2_a), .ws(ws_a), .stall_cnt(cnt_a));

   hazard_scoreboard #(.DEPTH(DEPTH), .LATE_LAT(LATE_LAT), .JUMP_LATE(1)) dut_b (
      .clk(clk), .rst_n(rst_n), .id_inst(id_inst), .id_valid(id_valid), .flush(flush),
      .stall(stall_b), .fwd_rs1(f1_b), .fwd_rs2(f2_b), .ws(ws_b), .stall_cnt(cnt_b));

   typedef struct packed { logic v; logic [4:0] rd; logic we; logic late; } rec_t;
   typedef struct packed { logic we, late, u1, u2; logic [4:0] rd, rs1, rs2; } dec_t;
   typedef struct packed { logic stall; logic [SELW-1:0] f1, f2; logic [4:0] ws; logic [31:0] cnt; } exp_t;

   rec_t   qa[$], qb[$];        // front = EX
   exp_t   exq_a[$], exq_b[$];
   longint mcnt_a = 0, mcnt_b = 0;
   bit     known = 0;
   logic   last_stall_a = 1'b0;
   int     compared = 0, mismatched = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
      end
   endtask

   function automatic dec_t decode(input logic [31:0] ins, input bit jl);
      dec_t d;
      d     = '0;
      d.rd  = ins[11:7];
      d.rs1 = ins[19:15];
      d.rs2 = ins[24:20];
      case (ins[6:2])
         5'b01100, 5'b01000, 5'b11000: begin d.u1 = 1; d.u2 = 1; end
         5'b00100, 5'b00000, 5'b11001: d.u1 = 1;
         default: ;
      endcase
      case (ins[6:2])
         5'b01100, 5'b00100, 5'b00000, 5'b01101, 5'b00101, 5'b11011, 5'b11001: d.we = (d.rd != 0);
         default: d.we = 0;
      endcase
      d.late = (ins[6:2] == 5'b00000) || (jl && (ins[6:2] == 5'b11011 || ins[6:2] == 5'b11001));
      return d;
   endfunction

   function automatic int find(input rec_t q[$], input logic [4:0] s);
      if (s == 0) return -1;
      foreach (q[k]) if (q[k].v && q[k].we && q[k].rd == s) return k;
      return -1;
   endfunction

   function automatic exp_t predict(input rec_t q[$], input dec_t d, input logic v,
                                    input logic fl, input longint cnt);
      exp_t e;
      int   k1, k2;
      bit   h1, h2;
      k1 = find(q, d.rs1);
      k2 = find(q, d.rs2);
      h1 = d.u1 && (k1 >= 0) && (k1 < LATE_LAT) && q[k1 < 0 ? 0 : k1].late;
      h2 = d.u2 && (k2 >= 0) && (k2 < LATE_LAT) && q[k2 < 0 ? 0 : k2].late;
      e.f1    = (v && k1 >= 0) ? SELW'(k1 + 1) : '0;
      e.f2    = (v && k2 >= 0) ? SELW'(k2 + 1) : '0;
      e.ws    = d.rd;
      e.stall = v && !fl && (h1 || h2);
      e.cnt   = 32'(cnt);
      return e;
   endfunction

   // One cycle: apply inputs, predict, advance the model on the edge.
   task automatic step(input logic r, input logic [31:0] ins, input logic v, input logic fl);
      dec_t da, db;
      exp_t ea, eb;
      rst_n = r; id_inst = ins; id_valid = v; flush = fl;
      da = decode(ins, 0);
      db = decode(ins, 1);
      ea = predict(qa, da, v, fl, mcnt_a);
      eb = predict(qb, db, v, fl, mcnt_b);
      if (known) begin
         exq_a.push_back(ea);
         exq_b.push_back(eb);
      end
      last_stall_a = ea.stall;
      @(posedge clk);
      if (!r) begin
         qa.delete(); qb.delete();
         mcnt_a = 0; mcnt_b = 0;
         known = 1;
      end else begin
         qa.push_front('{v: v && !ea.stall && !fl, rd: da.rd, we: da.we, late: da.late});
         qb.push_front('{v: v && !eb.stall && !fl, rd: db.rd, we: db.we, late: db.late});
         if (qa.size() > DEPTH) void'(qa.pop_back());
         if (qb.size() > DEPTH) void'(qb.pop_back());
         if (ea.stall && mcnt_a < CMAX) mcnt_a++;
         if (eb.stall && mcnt_b < CMAX) mcnt_b++;
      end
      #1;
   endtask

   // Monitor: outputs are combinational every cycle; compare mid-cycle.
   always @(negedge clk) begin
      exp_t e;
      if (exq_a.size() != 0) begin
         e = exq_a.pop_front();
         check("stall_a", 32'(stall_a), 32'(e.stall));
         check("fwd_rs1_a", 32'(f1_a), 32'(e.f1));
         check("fwd_rs2_a", 32'(f2_a), 32'(e.f2));
         check("ws_a", 32'(ws_a), 32'(e.ws));
         check("stall_cnt_a", cnt_a, e.cnt);
      end
      if (exq_b.size() != 0) begin
         e = exq_b.pop_front();
         check("stall_b", 32'(stall_b), 32'(e.stall));
         check("fwd_rs1_b", 32'(f1_b), 32'(e.f1));
         check("fwd_rs2_b", 32'(f2_b), 32'(e.f2));
         check("stall_cnt_b", cnt_b, e.cnt);
      end
   end

   function automatic logic [31:0] enc_r(input logic [4:0] rd, input logic [4:0] a, input logic [4:0] b);
      return {7'b0, b, a, 3'b000, rd, 7'b0110011};
   endfunction
   function automatic logic [31:0] enc_i(input logic [6:0] op, input logic [4:0] rd, input logic [4:0] a, input logic [11:0] imm);
      return {imm, a, 3'b000, rd, op};
   endfunction
   function automatic logic [31:0] enc_s(input logic [4:0] a, input logic [4:0] b);
      return {7'b0, b, a, 3'b010, 5'b0, 7'b0100011};
   endfunction
   function automatic logic [31:0] enc_b(input logic [4:0] a, input logic [4:0] b);
      return {7'b0, b, a, 3'b000, 5'b0, 7'b1100011};
   endfunction
   function automatic logic [31:0] enc_u(input logic [6:0] op, input logic [4:0] rd, input logic [19:0] imm);
      return {imm, rd, op};
   endfunction

   function automatic logic [31:0] rand_inst();
      logic [4:0] rd, a, b;
      rd = 5'($urandom_range(0, 7));
      a  = 5'($urandom_range(0, 7));
      b  = 5'($urandom_range(0, 7));
      case ($urandom_range(0, 9))
         0:       return enc_r(rd, a, b);
         1:       return enc_i(7'b0010011, rd, a, 12'($urandom));
         2:       return enc_i(7'b0000011, rd, a, 12'($urandom));
         3:       return enc_s(a, b);
         4:       return enc_b(a, b);
         5:       return enc_u(7'b0110111, rd, 20'($urandom));
         6:       return enc_u(7'b0010111, rd, 20'($urandom));
         7:       return enc_u(7'b1101111, rd, 20'($urandom));
         8:       return enc_i(7'b1100111, rd, a, 12'($urandom));
         default: return {$urandom_range(0, 32'h7F) == 0 ? 25'h0 : 25'($urandom), 7'($urandom)};
      endcase
   endfunction

   localparam logic [6:0] I_OP = 7'b0010011, LD_OP = 7'b0000011, LUI_OP = 7'b0110111;
   localparam logic [6:0] JAL_OP = 7'b1101111, JALR_OP = 7'b1100111;

   initial begin
      logic [31:0] cur;
      // Reset with add x5 in ID
      step(0, enc_r(5, 1, 2), 1, 0);
      step(0, enc_r(5, 1, 2), 1, 0);
      // ALU chain
      step(1, enc_r(5, 1, 2), 1, 0);
      step(1, enc_r(6, 5, 5), 1, 0);
      step(1, enc_r(10, 5, 0), 1, 0);
      step(1, enc_r(11, 5, 0), 1, 0);
      step(1, enc_r(12, 5, 0), 1, 0);
      // Load-use
      step(1, enc_i(LD_OP, 7, 1, 12'h0), 1, 0);
      step(1, enc_r(8, 7, 3), 1, 0);
      step(1, enc_r(8, 7, 3), 1, 0);
      // Youngest wins, x0 never matches
      step(1, enc_i(I_OP, 4, 1, 12'h1), 1, 0);
      step(1, enc_i(I_OP, 4, 4, 12'h2), 1, 0);
      step(1, {7'b0100000, 5'd0, 5'd4, 3'b000, 5'd9, 7'b0110011}, 1, 0);
      step(1, enc_i(I_OP, 0, 1, 12'h1), 1, 0);
      step(1, enc_r(13, 0, 0), 1, 0);
      // Non-writers and source usage
      step(1, enc_r(5, 1, 2), 1, 0);
      step(1, enc_s(6, 5), 1, 0);
      step(1, enc_b(5, 5), 1, 0);
      step(1, enc_r(14, 5, 5), 1, 0);
      step(1, enc_u(LUI_OP, 3, 20'h12345), 1, 0);
      step(1, enc_u(JAL_OP, 3, 20'h0), 1, 0);
      // Flush during stall
      step(1, enc_i(LD_OP, 7, 1, 12'h0), 1, 0);
      step(1, enc_r(8, 7, 7), 1, 1);
      step(1, enc_r(8, 7, 7), 1, 0);
      // Late jumps (stall only in the JUMP_LATE=1 instance)
      step(1, enc_u(JAL_OP, 1, 20'h0), 1, 0);
      step(1, enc_i(I_OP, 2, 1, 12'h4), 1, 0);
      step(1, enc_i(I_OP, 2, 1, 12'h4), 1, 0);
      step(1, enc_i(JALR_OP, 1, 2, 12'h0), 1, 0);
      step(1, enc_r(3, 1, 1), 1, 0);
      step(1, enc_r(3, 1, 1), 1, 0);
      // Bubble in ID hides a hazard
      step(1, enc_i(LD_OP, 7, 1, 12'h0), 1, 0);
      step(1, enc_r(8, 7, 3), 0, 0);
      // Reset mid-stall
      step(1, enc_i(LD_OP, 7, 1, 12'h0), 1, 0);
      step(0, enc_r(8, 7, 3), 1, 0);
      step(1, enc_r(8, 7, 3), 1, 0);
      // Randomised traffic; a stalled instruction is held in ID
      cur = rand_inst();
      repeat (600) begin
         step(($urandom_range(0, 99) != 0), cur, ($urandom_range(0, 9) != 0),
              ($urandom_range(0, 11) == 0));
         if (!last_stall_a) cur = rand_inst();
      end
      step(1, 32'h0, 0, 0);
      check("queue_drain", 32'(exq_a.size() + exq_b.size()), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

endmodule
